// File: rtl/fancytimer_cmd_serializer_if.sv
// Command/timer handshake bundle for fancytimer_cmd_serializer.
//   cmd_valid / cmd_delay / cmd_ready : upstream command offer and accept
//   data                              : serial frame line to the timer
//   done / ack                        : timer completion and acknowledge
// slave  : serializer view (consumes commands, drives the timer line)
// master : producer/timer view (offers commands, answers with done)
interface fancytimer_cmd_serializer_if;
    logic       cmd_valid;
    logic [3:0] cmd_delay;
    logic       cmd_ready;
    logic       data;
    logic       done;
    logic       ack;

    modport master (
        output cmd_valid, cmd_delay, done,
        input  cmd_ready, data, ack
    );

    modport slave (
        input  cmd_valid, cmd_delay, done,
        output cmd_ready, data, ack
    );
endinterface

// File: rtl/fancytimer_cmd_serializer.sv
// Upstream command stage for the fancy timer. Queues 4-bit delay commands
// and sends each as an 8-bit frame {1101, delay[3:0]} MSB-first on data,
// waits for the timer's done, pulses ack, then holds an idle gap before
// the next frame. A watchdog aborts a command whose done never arrives.
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   cmd_if      command handshake + timer line (slave modport)
//   busy        state not IDLE or queue non-empty
//   fifo_level  number of queued commands
//   timeout_err sticky watchdog flag
//   err_clr     synchronous clear of timeout_err (a same-cycle set wins)
module fancytimer_cmd_serializer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    fancytimer_cmd_serializer_if.slave    cmd_if,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          timeout_err,
    input  logic                          err_clr
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int WDW = $clog2(TIMEOUT_CYCLES);
    localparam int GW  = $clog2(GAP_CYCLES + 1);

    localparam logic [AW:0]    DEPTH_V  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_ACK,
        S_GAP
    } state_t;

    // ---------------- command queue ----------------
    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [3:0]    head;

    state_t state;
    state_t state_n;

    assign full  = (count == DEPTH_V);
    assign empty = (count == '0);
    assign pop   = (state == S_IDLE) && !empty;
    // A full queue still takes a command on the edge that pops its head.
    assign push  = cmd_if.cmd_valid && (!full || pop);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_if.cmd_delay;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- frame state machine ----------------
    logic           data_q;
    logic           data_n;
    logic           ack_q;
    logic           ack_n;
    logic [6:0]     sr;        // frame bits still to send, next one in [6]
    logic [6:0]     sr_n;
    logic [2:0]     bit_cnt;
    logic [2:0]     bit_cnt_n;
    logic [WDW-1:0] wd_cnt;
    logic [WDW-1:0] wd_cnt_n;
    logic [GW-1:0]  gap_cnt;
    logic [GW-1:0]  gap_cnt_n;
    logic           set_err;
    logic [7:0]     frame;

    assign frame = {4'b1101, head};

    always_comb begin
        state_n   = state;
        data_n    = 1'b0;
        ack_n     = 1'b0;
        sr_n      = sr;
        bit_cnt_n = bit_cnt;
        wd_cnt_n  = wd_cnt;
        gap_cnt_n = gap_cnt;
        set_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    data_n    = frame[7];
                    sr_n      = frame[6:0];
                    bit_cnt_n = '0;
                    state_n   = S_SEND;
                end
            end
            S_SEND: begin
                // bit 7 went out on entry; seven more shifts, then the 8th edge drops data
                if (bit_cnt == 3'd7) begin
                    state_n  = S_WAIT;
                    wd_cnt_n = '0;
                end else begin
                    data_n    = sr[6];
                    sr_n      = {sr[5:0], 1'b0};
                    bit_cnt_n = bit_cnt + 3'd1;
                end
            end
            S_WAIT: begin
                if (cmd_if.done) begin
                    state_n  = S_ACK;
                    ack_n    = 1'b1;
                    wd_cnt_n = '0;
                end else if (wd_cnt == WD_LAST) begin
                    set_err   = 1'b1;
                    state_n   = S_GAP;
                    gap_cnt_n = '0;
                    wd_cnt_n  = '0;
                end else begin
                    wd_cnt_n = wd_cnt + WDW'(1);
                end
            end
            S_ACK: begin
                state_n   = S_GAP;
                gap_cnt_n = '0;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            data_q      <= 1'b0;
            ack_q       <= 1'b0;
            sr          <= '0;
            bit_cnt     <= '0;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state   <= state_n;
            data_q  <= data_n;
            ack_q   <= ack_n;
            sr      <= sr_n;
            bit_cnt <= bit_cnt_n;
            wd_cnt  <= wd_cnt_n;
            gap_cnt <= gap_cnt_n;
            if (set_err) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    assign cmd_if.cmd_ready = !full;
    assign cmd_if.data      = data_q;
    assign cmd_if.ack       = ack_q;
    assign busy             = (state != S_IDLE) || !empty;
    assign fifo_level       = count;

endmodule

// File: tb/tb_fancytimer_cmd_serializer.sv
// Directed bench for fancytimer_cmd_serializer. Instance a uses the default
// watchdog; instance b uses TIMEOUT_CYCLES=50 for the abort scenario. A
// select bit routes the shared stimulus to one instance and its outputs to
// the observation signals. Inputs change and outputs are sampled on negedge.
`timescale 1ns/1ps
module tb_fancytimer_cmd_serializer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sel = 1'b0;
    logic       t_valid = 1'b0;
    logic [3:0] t_delay = '0;
    logic       t_done = 1'b0;
    logic       t_clr = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fancytimer_cmd_serializer_if if_a ();
    fancytimer_cmd_serializer_if if_b ();

    logic       busy_a, busy_b, err_a, err_b;
    logic [2:0] lvl_a, lvl_b;

    assign if_a.cmd_valid = t_valid & ~sel;
    assign if_a.cmd_delay = t_delay;
    assign if_a.done      = t_done & ~sel;
    assign if_b.cmd_valid = t_valid & sel;
    assign if_b.cmd_delay = t_delay;
    assign if_b.done      = t_done & sel;

    fancytimer_cmd_serializer dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_if     (if_a),
        .busy       (busy_a),
        .fifo_level (lvl_a),
        .timeout_err(err_a),
        .err_clr    (t_clr & ~sel)
    );

    fancytimer_cmd_serializer #(.TIMEOUT_CYCLES(50)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_if     (if_b),
        .busy       (busy_b),
        .fifo_level (lvl_b),
        .timeout_err(err_b),
        .err_clr    (t_clr & sel)
    );

    logic       o_data, o_ack, o_ready, o_busy, o_err;
    logic [2:0] o_level;
    assign o_data  = sel ? if_b.data      : if_a.data;
    assign o_ack   = sel ? if_b.ack       : if_a.ack;
    assign o_ready = sel ? if_b.cmd_ready : if_a.cmd_ready;
    assign o_busy  = sel ? busy_b         : busy_a;
    assign o_err   = sel ? err_b          : err_a;
    assign o_level = sel ? lvl_b          : lvl_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] d);
        t_valid = 1'b1;
        t_delay = d;
        @(negedge clk);
        t_valid = 1'b0;
    endtask

    // Waits (bounded) for the start bit, captures the frame, returns the
    // number of zero samples seen before it.
    task automatic recv_frame(input logic [3:0] d, input string tag, output int zc);
        logic [7:0] f;
        logic       ack_seen;
        ack_seen = 1'b0;
        zc = 0;
        for (int i = 0; i < 40 && o_data !== 1'b1; i++) begin
            ack_seen |= o_ack;
            zc++;
            @(negedge clk);
        end
        check({tag, "_start"}, 32'(o_data), 32'd1);
        f[7] = o_data;
        for (int k = 6; k >= 0; k--) begin
            @(negedge clk);
            ack_seen |= o_ack;
            f[k] = o_data;
        end
        check({tag, "_frame"}, 32'(f), 32'({4'b1101, d}));
        @(negedge clk);
        check({tag, "_tail0"}, 32'(o_data), 32'd0);
        check({tag, "_noack_send"}, 32'(ack_seen), 32'd0);
    endtask

    // Holds done low for n cycles of WAIT_DONE, then answers with done.
    task automatic finish_frame(input int n, input string tag);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            bad |= o_ack | o_data;
            @(negedge clk);
        end
        check({tag, "_wait_quiet"}, 32'(bad), 32'd0);
        t_done = 1'b1;
        @(negedge clk);
        t_done = 1'b0;
        check({tag, "_ack_hi"}, 32'(o_ack), 32'd1);
        @(negedge clk);
        check({tag, "_ack_lo"}, 32'(o_ack), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int         zc;
        logic       bad;
        logic [3:0] seq [4];
        logic [3:0] rest [4];
        seq  = '{4'h3, 4'hA, 4'hF, 4'h1};
        rest = '{4'hA, 4'hF, 4'h1, 4'h6};

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_data",  32'(o_data),  32'd0);
        check("rst_ack",   32'(o_ack),   32'd0);
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_err",   32'(o_err),   32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // ---- single command, delay 0, done 1000 cycles later ----
        push(4'h0);
        check("t1_level", 32'(o_level), 32'd1);
        check("t1_busy",  32'(o_busy),  32'd1);
        recv_frame(4'h0, "t1", zc);
        check("t1_latency", 32'(zc), 32'd1);
        finish_frame(1000, "t1");
        bad = o_data;
        @(negedge clk);
        bad |= o_data;
        @(negedge clk);
        bad |= o_data;
        check("t1_gap_zero", 32'(bad), 32'd0);
        check("t1_idle_busy", 32'(o_busy), 32'd0);

        // ---- fill queue during WAIT_DONE, overflow drop, push at pop edge ----
        push(4'h5);
        recv_frame(4'h5, "t2_lead", zc);
        check("t2_lead_latency", 32'(zc), 32'd1);
        for (int i = 0; i < 4; i++) begin
            t_valid = 1'b1;
            t_delay = seq[i];
            @(negedge clk);
        end
        t_valid = 1'b0;
        check("t2_level_full", 32'(o_level), 32'd4);
        check("t2_ready_low",  32'(o_ready), 32'd0);
        push(4'h7);
        check("t2_drop_level", 32'(o_level), 32'd4);
        finish_frame(5, "t2_lead");
        bad = o_data;
        @(negedge clk);
        bad |= o_data;
        @(negedge clk);
        bad |= o_data;
        check("t3_gap_zero", 32'(bad), 32'd0);
        check("t3_level_pre", 32'(o_level), 32'd4);
        t_valid = 1'b1;
        t_delay = 4'h6;
        @(negedge clk);
        t_valid = 1'b0;
        check("t3_level_kept", 32'(o_level), 32'd4);
        recv_frame(4'h3, "t2_f3", zc);
        check("t2_f3_gap", 32'(zc), 32'd0);
        finish_frame(3, "t2_f3");
        for (int i = 0; i < 4; i++) begin
            recv_frame(rest[i], $sformatf("t2_q%0d", i), zc);
            check($sformatf("t2_q%0d_gap", i), 32'(zc), 32'd3);
            finish_frame(3, $sformatf("t2_q%0d", i));
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bad |= o_data;
            @(negedge clk);
        end
        check("t2_no_extra", 32'(bad), 32'd0);
        check("t2_empty", 32'(o_level), 32'd0);
        check("t2_busy_end", 32'(o_busy), 32'd0);

        // ---- watchdog on the TIMEOUT_CYCLES=50 instance ----
        sel = 1'b1;
        @(negedge clk);
        push(4'h9);
        push(4'hC);
        recv_frame(4'h9, "t4_f9", zc);
        bad = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            bad |= o_ack;
            if (k < 50) bad |= o_err;
        end
        check("t4_quiet_wait", 32'(bad), 32'd0);
        check("t4_err_set", 32'(o_err), 32'd1);
        recv_frame(4'hC, "t4_fc", zc);
        check("t4_fc_gap", 32'(zc), 32'd3);
        finish_frame(5, "t4_fc");
        check("t4_err_sticky", 32'(o_err), 32'd1);
        t_clr = 1'b1;
        @(negedge clk);
        t_clr = 1'b0;
        check("t4_err_clr", 32'(o_err), 32'd0);

        // ---- async reset in the middle of SEND ----
        sel = 1'b0;
        @(negedge clk);
        push(4'h8);
        push(4'h4);
        check("t5_first_bit", 32'(o_data), 32'd1);
        check("t5_level_pre", 32'(o_level), 32'd1);
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_data",  32'(o_data),  32'd0);
        check("t5_rst_ack",   32'(o_ack),   32'd0);
        check("t5_rst_level", 32'(o_level), 32'd0);
        check("t5_rst_busy",  32'(o_busy),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            bad |= o_data | o_busy;
        end
        check("t5_silent", 32'(bad), 32'd0);
        push(4'h2);
        recv_frame(4'h2, "t5_f2", zc);
        check("t5_f2_latency", 32'(zc), 32'd1);
        finish_frame(5, "t5_f2");

        // ---- done asserted outside WAIT_DONE ----
        repeat (3) @(negedge clk);
        t_done = 1'b1;
        push(4'hE);
        recv_frame(4'hE, "t6_fe", zc);
        t_done = 1'b0;
        finish_frame(10, "t6_fe");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
